// File: rtl/mpc_mux_pipe_n.sv
// rtl/mpc_mux_pipe_n.sv - pipelined N:1 word mux with ce stall, valid tracking and select-range flag
module mpc_mux_pipe_n #(
  parameter int ID         = 0,
  parameter int NUM_INPUTS = 6,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3,
  parameter int NUM_STAGE  = 2
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic                           ce,
  input  logic                           din_vld,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] din,
  input  logic [SEL_WIDTH-1:0]           sel,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           dout_vld,
  output logic                           sel_err
);

  localparam int LEAVES    = 1 << SEL_WIDTH;
  localparam int FIRST_REG = SEL_WIDTH - NUM_STAGE + 1;
  localparam logic [SEL_WIDTH:0] NUM_IN_W = NUM_INPUTS[SEL_WIDTH:0];

  if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_inputs
    $error("mpc_mux_pipe_n %0d: NUM_INPUTS out of range", ID);
  end
  if (SEL_WIDTH != $clog2(NUM_INPUTS)) begin : g_bad_sel
    $error("mpc_mux_pipe_n %0d: SEL_WIDTH must equal clog2(NUM_INPUTS)", ID);
  end
  if (NUM_STAGE < 1 || NUM_STAGE > SEL_WIDTH) begin : g_bad_stage
    $error("mpc_mux_pipe_n %0d: NUM_STAGE out of range", ID);
  end

  // Heap-indexed tree: root at 1, children of i at 2i/2i+1, leaves at LEAVES..2*LEAVES-1.
  logic [DATA_WIDTH-1:0] node [1:2*LEAVES-1];
  // lsel[k] is the select belonging to the item currently at the output of level k.
  logic [SEL_WIDTH-1:0]  lsel [SEL_WIDTH];

  assign lsel[0] = sel;

  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < NUM_INPUTS) begin : g_word
      assign node[LEAVES+j] = din[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign node[LEAVES+j] = '0;
    end
  end

  for (genvar k = 1; k <= SEL_WIDTH; k++) begin : g_lvl
    localparam int LO = LEAVES >> k;
    logic [DATA_WIDTH-1:0] m [LO];

    for (genvar j = 0; j < LO; j++) begin : g_mux
      assign m[j] = lsel[k-1][k-1] ? node[2*(LO+j)+1] : node[2*(LO+j)];
    end

    if (k >= FIRST_REG) begin : g_reg
      logic [DATA_WIDTH-1:0] q [LO];

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int j = 0; j < LO; j++) q[j] <= '0;
        end else if (ce) begin
          q <= m;
        end
      end

      for (genvar j = 0; j < LO; j++) begin : g_out
        assign node[LO+j] = q[j];
      end

      if (k < SEL_WIDTH) begin : g_sel
        logic [SEL_WIDTH-1:0] sq;
        always_ff @(posedge ap_clk) begin
          if (ce) sq <= lsel[k-1];
        end
        assign lsel[k] = sq;
      end
    end else begin : g_comb
      for (genvar j = 0; j < LO; j++) begin : g_out
        assign node[LO+j] = m[j];
      end
      if (k < SEL_WIDTH) begin : g_sel
        assign lsel[k] = lsel[k-1];
      end
    end
  end

  assign dout = node[1];

  // Constant-false compare when NUM_INPUTS is a power of two.
  logic err_in;
  assign err_in = din_vld && ({1'b0, sel} >= NUM_IN_W);

  logic [NUM_STAGE-1:0] vld_sr;
  logic [NUM_STAGE-1:0] err_sr;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_sr <= '0;
      err_sr <= '0;
    end else if (ce) begin
      vld_sr[0] <= din_vld;
      err_sr[0] <= err_in;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        err_sr[i] <= err_sr[i-1];
      end
    end
  end

  assign dout_vld = vld_sr[NUM_STAGE-1];
  assign sel_err  = err_sr[NUM_STAGE-1];

endmodule

// File: tb/tb_mpc_mux_pipe_n.sv
// tb/tb_mpc_mux_pipe_n.sv - scoreboard bench for mpc_mux_pipe_n across three parameter sets
module tb_mpc_mux_pipe_n;

  localparam int DW = 32;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          tag;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           ce;
  logic           din_vld;
  logic [16*DW-1:0] din;
  logic [3:0]     sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected item from the selection rule: in-range index picks its word, anything else is a zero pad.
  function automatic exp_t model(int ni, int sw, logic [16*DW-1:0] d, logic [3:0] s, int tag);
    exp_t e;
    int idx;
    idx = int'(s) & ((1 << sw) - 1);
    e.err  = (idx >= ni);
    e.data = e.err ? 32'h0 : d[idx*DW +: DW];
    e.tag  = tag;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NI = (g == 0) ? 6 : 16;
    localparam int SW = (g == 0) ? 3 : 4;
    localparam int NS = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          sel_err;

    mpc_mux_pipe_n #(
      .ID(g), .NUM_INPUTS(NI), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .NUM_STAGE(NS)
    ) u_dut (
      .ap_clk  (clk),
      .ap_rst  (rst),
      .ce      (ce),
      .din_vld (din_vld),
      .din     (din[NI*DW-1:0]),
      .sel     (sel[SW-1:0]),
      .dout    (dout),
      .dout_vld(dout_vld),
      .sel_err (sel_err)
    );

    exp_t q[$];
    exp_t held;
    logic held_vld = 1'b0;
    int   ce_cnt = 0;

    // Sampler: records every item the DUT accepts at this edge.
    always @(posedge clk) begin
      if (rst) begin
        q.delete();
      end else if (ce) begin
        ce_cnt++;
        if (din_vld) q.push_back(model(NI, SW, din, sel, ce_cnt));
      end
    end

    // Monitor: an item is due once NS ce-qualified edges (including its own) have passed.
    always @(posedge clk) begin
      logic exp_vld;
      exp_t e;
      #1;
      if (rst) begin
        chk($sformatf("rst_dout%0d", g), dout, 32'h0);
        chk($sformatf("rst_vld%0d", g), 32'(dout_vld), 32'h0);
        chk($sformatf("rst_err%0d", g), 32'(sel_err), 32'h0);
        held_vld = 1'b0;
      end else if (ce) begin
        exp_vld = (q.size() > 0) && (q[0].tag + NS - 1 == ce_cnt);
        chk($sformatf("vld%0d", g), 32'(dout_vld), 32'(exp_vld));
        if (exp_vld) begin
          e = q.pop_front();
          chk($sformatf("dout%0d", g), dout, e.data);
          chk($sformatf("err%0d", g), 32'(sel_err), 32'(e.err));
          held = e;
        end
        held_vld = exp_vld;
      end else begin
        chk($sformatf("stall_vld%0d", g), 32'(dout_vld), 32'(held_vld));
        if (held_vld) begin
          chk($sformatf("stall_dout%0d", g), dout, held.data);
          chk($sformatf("stall_err%0d", g), 32'(sel_err), 32'(held.err));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] s, input logic c);
    din_vld = v;
    sel     = s;
    ce      = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    din_vld = 1'b0;
    sel = '0;
    for (int i = 0; i < 16; i++) din[i*DW +: DW] = 32'h10 + i;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single item, sel=3
    step(1, 3, 1);
    repeat (5) step(0, 0, 1);

    // Back-to-back 0,5,2,1
    step(1, 0, 1); step(1, 5, 1); step(1, 2, 1); step(1, 1, 1);
    repeat (5) step(0, 0, 1);

    // Out-of-range 6,7 then 4
    step(1, 6, 1); step(1, 7, 1); step(1, 4, 1);
    repeat (5) step(0, 0, 1);

    // Stall after the first item
    step(1, 1, 1);
    repeat (3) step(1, 2, 0);
    step(1, 2, 1);
    repeat (5) step(0, 0, 1);

    // Reset with items in flight; item offered during reset is dropped
    step(1, 1, 1); step(1, 2, 1);
    rst = 1'b1;
    step(1, 3, 1);
    rst = 1'b0;
    step(1, 4, 1);
    repeat (6) step(0, 0, 1);

    // Randomized run
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 16; i++) din[i*DW +: DW] = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 8);
    end
    rst = 1'b0;
    repeat (8) step(0, 0, 1);

    chk("drain_q0", 32'(g_dut[0].q.size()), 32'h0);
    chk("drain_q1", 32'(g_dut[1].q.size()), 32'h0);
    chk("drain_q2", 32'(g_dut[2].q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
